// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states,
// status-word bit positions and frame geometry.
`ifndef XLEN
`define XLEN 32
`endif

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_FULL    = 2;
    localparam int STAT_CNT_LSB = 8;

    // Start bit + 8 data bits + stop bit
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Pushes into a full FIFO and pops
// from an empty FIFO are ignored. The head entry is visible combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; a simultaneous push and pop leaves count alone
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Bus writes push bytes into a FIFO, bus
// reads return a status word, and a four-state FSM serialises each byte
// onto txd at CLK_DIV clocks per bit, chaining frames with no idle gap.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int XLEN       = `XLEN
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            cen,
    input  logic            wr,
    input  logic [7:0]      wdata,
    output logic [XLEN-1:0] rdata,
    output logic            error,
    output logic            txd,
    output logic            busy
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(FRAME_BITS - 3);

    uart_state_t     state;
    uart_state_t     state_n;
    logic [15:0]     baud_cnt;
    logic [15:0]     baud_n;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_n;
    logic [7:0]      shift;
    logic [7:0]      shift_n;
    logic            txd_n;
    logic            baud_done;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [7:0]      head;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] status;

    // Full comes from the registered count, so a same-cycle pop never makes room
    assign push      = cen && wr && !full;
    assign error     = cen && wr && full;
    assign baud_done = (baud_cnt == BAUD_LAST);
    assign busy      = (state != IDLE) || !empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Assemble the status word that software polls before writing
    always_comb begin
        status                        = '0;
        status[STAT_BUSY]             = (state != IDLE);
        status[STAT_EMPTY]            = empty;
        status[STAT_FULL]             = full;
        status[STAT_CNT_LSB +: 8]     = 8'(count);
    end

    assign rdata = (cen && !wr) ? status : '0;

    // FSM, baud counter, shift register and registered txd
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            txd      <= txd_n;
        end
    end

    // Next-state logic; the shift register moves right so the next data bit is always shift[1]
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        txd_n   = txd;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    txd_n   = 1'b0;
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    txd_n   = shift[0];
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (bit_idx == LAST_BIT) begin
                        txd_n   = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_n   = bit_idx + 3'd1;
                        shift_n = {1'b0, shift[7:1]};
                        txd_n   = shift[1];
                    end
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        txd_n   = 1'b0;
                        bit_n   = '0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end

`ifndef SYNTHESIS
    // Echo each character to the console as it leaves the FIFO
    always @(posedge clk) begin
        if (rstn && pop) begin
            $write("%c", head);
        end
    end
`endif

endmodule
